// File: rtl/fetch_prefetch.sv
// Instruction-fetch unit: pipelined imem requests feeding a DEPTH-entry prefetch queue,
// with redirect flush and discard of stale in-flight responses.
module fetch_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pcplus4
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] rpc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outst;
    logic [CW-1:0]   drop;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            init_q;

    logic [31:0]     q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];

    logic [CW:0]     credit_used;
    logic            grant;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outst_redir;

    // Live in-flight requests plus queued entries must never exceed the queue size.
    assign credit_used = {1'b0, count} + {1'b0, outst - drop};
    assign imem_req    = ~reset & ~init_q & ~redirect_valid & (credit_used < DEPTH_C);
    assign imem_addr   = fpc;

    assign grant       = imem_req & imem_gnt;
    assign push        = imem_rvalid & (drop == '0);
    assign pop         = out_valid & out_ready;
    assign target      = redirect_pc & ~XLEN'(3);
    assign outst_redir = outst - CW'(imem_rvalid);

    assign out_valid   = ~reset & (count != '0);
    assign out_instr   = q_instr[rd_ptr];
    assign out_pc      = q_pc[rd_ptr];
    assign out_pcplus4 = out_pc + XLEN'(4);

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc    <= RESET_PC;
            rpc    <= RESET_PC;
            count  <= '0;
            outst  <= '0;
            drop   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            init_q <= 1'b1;
        end else begin
            init_q <= 1'b0;
            if (redirect_valid) begin
                // Everything still in flight becomes stale; a response landing now is consumed here.
                fpc    <= target;
                rpc    <= target;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                outst  <= outst_redir;
                drop   <= outst_redir;
            end else begin
                if (grant) begin
                    fpc <= fpc + XLEN'(4);
                end
                outst <= outst + CW'(grant) - CW'(imem_rvalid);
                if (imem_rvalid && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    rpc    <= rpc + XLEN'(4);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !redirect_valid && push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= rpc;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !redirect_valid && (count == FULL_C)));

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: queue-based reference model checked every cycle,
// plus literal expectations on the key scenarios.
module tb_fetch_prefetch;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h80;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;

    always #5 clk = ~clk;

    fetch_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pcplus4    (out_pcplus4)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

    int          vectors = 0;
    int          errs    = 0;
    int          cyc     = 0;
    int          lat     = 1;
    mreq_t       mq[$];      // memory pipeline
    ent_t        q_exp[$];   // expected decode-side queue
    bit          stale[$];   // one flag per in-flight request, set by redirect
    logic [31:0] m_fpc, m_rpc;
    bit          prev_reset;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr, s_p4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive memory response, sample, compare with model, advance model.
    task automatic step();
        bit   e_req, e_valid;
        int   live_n;
        ent_t e;
        mreq_t m;
        @(negedge clk);
        if (mq.size() > 0 && mq[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        s_req = imem_req;  s_addr = imem_addr; s_valid = out_valid;
        s_pc  = out_pc;    s_instr = out_instr; s_p4 = out_pcplus4;

        live_n = 0;
        foreach (stale[i]) if (!stale[i]) live_n++;
        e_req   = !reset && !prev_reset && !redirect_valid && (q_exp.size() + live_n < DEPTH);
        e_valid = !reset && (q_exp.size() > 0);
        chk("imem_req", {31'b0, s_req}, {31'b0, e_req});
        if (e_req) chk("imem_addr", s_addr, m_fpc);
        chk("out_valid", {31'b0, s_valid}, {31'b0, e_valid});
        if (e_valid && s_valid) begin
            chk("out_pc", s_pc, q_exp[0].pc);
            chk("out_instr", s_instr, q_exp[0].instr);
            chk("out_pcplus4", s_p4, q_exp[0].pc + 32'd4);
        end

        if (reset) begin
            q_exp.delete(); stale.delete(); mq.delete();
            m_fpc = RST_PC; m_rpc = RST_PC;
        end else if (redirect_valid) begin
            if (imem_rvalid) begin
                void'(stale.pop_front());
                void'(mq.pop_front());
            end
            foreach (stale[i]) stale[i] = 1'b1;
            q_exp.delete();
            m_fpc = redirect_pc & ~32'h3;
            m_rpc = m_fpc;
        end else begin
            if (e_valid && out_ready) void'(q_exp.pop_front());
            if (imem_rvalid) begin
                void'(mq.pop_front());
                if (stale.pop_front() == 1'b0) begin
                    e.instr = imem_rdata; e.pc = m_rpc;
                    q_exp.push_back(e);
                    m_rpc += 32'd4;
                end
            end
            if (s_req && imem_gnt) begin
                m.addr = s_addr; m.due = cyc + lat;
                mq.push_back(m);
                stale.push_back(1'b0);
                m_fpc += 32'd4;
            end
        end
        prev_reset = reset;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (s_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            vectors++; errs++;
            $display("FAIL wait_valid: no out_valid within %0d cycles", budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int          n;
        int          k;
        bit          seen;
        bit          found;
        logic [31:0] got [4];
        logic [31:0] fa;

        reset = 1; redirect_valid = 0; redirect_pc = 0; out_ready = 1;
        imem_gnt = 1; imem_rvalid = 0; imem_rdata = 0;
        prev_reset = 1; m_fpc = RST_PC; m_rpc = RST_PC;
        @(posedge clk); #1;

        // Reset, 1-cycle memory, streaming
        repeat (3) step();
        chk("reset_req", {31'b0, s_req}, 32'd0);
        chk("reset_valid", {31'b0, s_valid}, 32'd0);
        reset = 0;
        step(); chk("init_req", {31'b0, s_req}, 32'd0);
        step(); chk("first_req", {31'b0, s_req}, 32'd1); chk("first_addr", s_addr, 32'h80);
        step(); chk("lat_valid", {31'b0, s_valid}, 32'd0);
        step(); chk("t1_pc0", s_pc, 32'h80); chk("t1_instr0", s_instr, 32'h5A5A_0093);
                chk("t1_p4", s_p4, 32'h84);
        step(); chk("t1_pc1", s_pc, 32'h84);
        step(); chk("t1_pc2", s_pc, 32'h88);
        imem_gnt = 0;
        repeat (3) step();
        chk("stall_req_held", {31'b0, s_req}, 32'd1);
        imem_gnt = 1;

        // Backpressure: queue fills, then drains in order
        redirect_valid = 1; redirect_pc = 32'h0; out_ready = 0;
        step();
        redirect_valid = 0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_req) n++;
        end
        chk("t2_req_count", n, 32'd4);
        chk("t2_req_idle", {31'b0, s_req}, 32'd0);
        out_ready = 1; k = 0; seen = 0; fa = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_valid && k < 4) begin got[k] = s_pc; k++; end
            if (s_req && !seen) begin seen = 1; fa = s_addr; end
        end
        chk("t2_drain0", got[0], 32'h0);
        chk("t2_drain1", got[1], 32'h4);
        chk("t2_drain2", got[2], 32'h8);
        chk("t2_drain3", got[3], 32'hC);
        chk("t2_resume_addr", fa, 32'h10);

        // Redirect with 3 outstanding at latency 3
        lat = 3;
        repeat (8) step();
        found = 0;
        for (int i = 0; i < 30; i++) begin
            if (stale.size() == 3) begin found = 1; break; end
            step();
        end
        chk("t3_found_3_outstanding", {31'b0, found}, 32'd1);
        redirect_valid = 1; redirect_pc = 32'h103;
        step();
        redirect_valid = 0;
        step(); chk("t3_req", {31'b0, s_req}, 32'd1); chk("t3_addr", s_addr, 32'h100);
        wait_valid(20);
        chk("t3_pc", s_pc, 32'h100);
        chk("t3_instr", s_instr, 32'h5A5A_0113);

        // Redirect coinciding with a response and a pop, count=2
        found = 0;
        for (int i = 0; i < 60; i++) begin
            if (q_exp.size() == 2 && mq.size() > 0 && mq[0].due == cyc) begin found = 1; break; end
            out_ready = (q_exp.size() >= 2);
            step();
        end
        chk("t4_found_setup", {31'b0, found}, 32'd1);
        out_ready = 1; redirect_valid = 1; redirect_pc = 32'h200;
        step();
        chk("t4_valid_at_redirect", {31'b0, s_valid}, 32'd1);
        redirect_valid = 0;
        step(); chk("t4_flushed", {31'b0, s_valid}, 32'd0);
        wait_valid(20);
        chk("t4_pc", s_pc, 32'h200);
        chk("t4_instr", s_instr, 32'h5A5A_0213);

        // Reset mid-stream with requests outstanding
        repeat (5) step();
        reset = 1;
        repeat (2) step();
        chk("t5_req_in_reset", {31'b0, s_req}, 32'd0);
        chk("t5_valid_in_reset", {31'b0, s_valid}, 32'd0);
        reset = 0;
        step(); chk("t5_init_req", {31'b0, s_req}, 32'd0); chk("t5_init_valid", {31'b0, s_valid}, 32'd0);
        step(); chk("t5_req", {31'b0, s_req}, 32'd1); chk("t5_addr", s_addr, 32'h80);
        wait_valid(20);
        chk("t5_pc", s_pc, 32'h80);
        chk("t5_instr", s_instr, 32'h5A5A_0093);

        // Address wrap at the top of the space
        reset = 1;
        step();
        lat = 1; reset = 0;
        step();
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 0;
        step(); chk("t6_addr_top", s_addr, 32'hFFFF_FFFC);
        step(); chk("t6_req_wrap", {31'b0, s_req}, 32'd1); chk("t6_addr_wrap", s_addr, 32'h0);
        wait_valid(10);
        chk("t6_pc_top", s_pc, 32'hFFFF_FFFC);
        chk("t6_p4_wrap", s_p4, 32'h0);
        chk("t6_instr_top", s_instr, 32'hA5A5_FFEF);
        step(); chk("t6_pc_zero", s_pc, 32'h0); chk("t6_p4_zero", s_p4, 32'h4);
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
